// File: rtl/shenjing_axon_pkg.sv
// -----------------------------------------------------------------------------
// shenjing_axon_pkg
// Shared types and defaults for the axon collector slice.
//   fill_state_e     : states of the frame fill FSM
//   DEF_AXON_NUM     : default axon bits per frame
//   DEF_SPIKE_REG_W  : default bits per stored word
//   word_addr_width(): word address width for a given frame/word geometry
// -----------------------------------------------------------------------------
package shenjing_axon_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COLLECT   = 2'd1,
        FLUSH     = 2'd2,
        WAIT_SWAP = 2'd3
    } fill_state_e;

    localparam int DEF_AXON_NUM    = 256;
    localparam int DEF_SPIKE_REG_W = 16;

    function automatic int word_addr_width(input int axon_num, input int reg_width);
        return $clog2(axon_num / reg_width);
    endfunction

endpackage

// File: rtl/axon_pingpong_bank.sv
// -----------------------------------------------------------------------------
// axon_pingpong_bank
// Two flop banks used as ping-pong frame storage. One bank (the fill bank) is
// written by the collector; the other (the published bank) is read by the core.
//   clk, rstb   : clock, synchronous active-low reset (both banks cleared,
//                 fill bank = 0)
//   clr_fill    : zero every word of the fill bank (wins over wr_en)
//   wr_en/addr/data : single write port into the fill bank
//   swap        : exchange the roles of the two banks
//   rd_en/rd_addr   : read strobe and word index into the published bank
//   rd_data     : registered read word, holds when rd_en=0
// -----------------------------------------------------------------------------
module axon_pingpong_bank #(
    parameter int WORDS = 16,
    parameter int W     = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          clr_fill,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          swap,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem_q [2][WORDS];
    logic [W-1:0] mem_d [2][WORDS];
    logic         fill_sel_q;
    logic         fill_sel_d;
    logic [W-1:0] rd_data_q;
    logic [W-1:0] rd_data_d;
    logic         pub_sel;

    assign pub_sel = ~fill_sel_q;
    assign rd_data = rd_data_q;

    always_comb begin
        mem_d      = mem_q;
        fill_sel_d = fill_sel_q;
        rd_data_d  = rd_data_q;

        if (clr_fill) begin
            for (int k = 0; k < WORDS; k++) begin
                mem_d[fill_sel_q][k] = '0;
            end
        end else if (wr_en) begin
            mem_d[fill_sel_q][wr_addr] = wr_data;
        end

        // A read in the swap cycle still sees the previously published bank.
        if (rd_en) begin
            rd_data_d = mem_q[pub_sel][rd_addr];
        end

        if (swap) begin
            fill_sel_d = ~fill_sel_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < WORDS; k++) begin
                    mem_q[b][k] <= '0;
                end
            end
            fill_sel_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            mem_q      <= mem_d;
            fill_sel_q <= fill_sel_d;
            rd_data_q  <= rd_data_d;
        end
    end

endmodule

// File: rtl/axon_collector.sv
// -----------------------------------------------------------------------------
// axon_collector
// Deserialises the serial crossbar spike stream into AXON_NUM-bit frames held
// as SPIKE_REG_WIDTH-bit words, stores them ping-pong and publishes each
// completed frame to the neuron core.
//   clk, rstb        : clock, synchronous active-low reset
//   frame_start      : opens a new fill frame, clears overflow
//   spike_valid/in   : one spike per valid cycle
//   frame_end        : closes the current fill frame
//   rd_en/addr/data  : word read of the published bank, 1-cycle latency
//   frame_ready      : a published frame is readable
//   frame_ack        : core is done with the published frame
//   busy             : fill FSM not in IDLE
//   overflow         : sticky, a spike was dropped
//   bit_count        : spikes accepted in the current frame
//
// Publish handshake: frame_ready is the "valid" side and frame_ack the
// "ready" side. A frame is handed over when frame_ready=1 and frame_ack=1 in
// the same cycle; frame_ready then drops next cycle unless a newly filled
// frame is swapped in that very cycle, in which case it stays high for the
// new frame. frame_ack while frame_ready=0 has no effect. A filled frame
// waits (WAIT_SWAP) while the previous one is still unacknowledged.
// -----------------------------------------------------------------------------
module axon_collector
    import shenjing_axon_pkg::*;
#(
    parameter int AXON_NUM        = DEF_AXON_NUM,
    parameter int SPIKE_REG_WIDTH = DEF_SPIKE_REG_W,
    parameter int WORD_ADDR_WIDTH = word_addr_width(AXON_NUM, SPIKE_REG_WIDTH),
    parameter int CNT_WIDTH       = $clog2(AXON_NUM) + 1
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       frame_start,
    input  logic                       spike_valid,
    input  logic                       spike_in,
    input  logic                       frame_end,
    input  logic                       rd_en,
    input  logic [WORD_ADDR_WIDTH-1:0] rd_addr,
    output logic [SPIKE_REG_WIDTH-1:0] rd_data,
    output logic                       frame_ready,
    input  logic                       frame_ack,
    output logic                       busy,
    output logic                       overflow,
    output logic [CNT_WIDTH-1:0]       bit_count
);

    localparam int LOW_W = $clog2(SPIKE_REG_WIDTH);
    localparam int WORDS = AXON_NUM / SPIKE_REG_WIDTH;
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(AXON_NUM);
    localparam logic [LOW_W-1:0]     LAST_BIT   = LOW_W'(SPIKE_REG_WIDTH - 1);

    fill_state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]       bit_count_q, bit_count_d;
    logic [SPIKE_REG_WIDTH-1:0] staging_q, staging_d;
    logic                       overflow_q, overflow_d;
    logic                       frame_ready_q, frame_ready_d;

    logic                       clr_fill;
    logic                       wr_en;
    logic [WORD_ADDR_WIDTH-1:0] wr_addr;
    logic [SPIKE_REG_WIDTH-1:0] wr_data;
    logic                       swap;
    logic [LOW_W-1:0]           bit_idx;
    logic [WORD_ADDR_WIDTH-1:0] word_idx;

    assign bit_idx  = bit_count_q[LOW_W-1:0];
    assign word_idx = WORD_ADDR_WIDTH'(bit_count_q[CNT_WIDTH-2:LOW_W]);

    always_comb begin
        state_d       = state_q;
        bit_count_d   = bit_count_q;
        staging_d     = staging_q;
        overflow_d    = overflow_q;
        frame_ready_d = frame_ready_q;
        clr_fill      = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = word_idx;
        wr_data       = staging_q;
        swap          = 1'b0;

        if (frame_ack && frame_ready_q) begin
            frame_ready_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d     = COLLECT;
                    bit_count_d = '0;
                    staging_d   = '0;
                    overflow_d  = 1'b0;
                    clr_fill    = 1'b1;
                end
            end

            COLLECT: begin
                if (frame_start) begin
                    // Restart discards the partial frame entirely.
                    bit_count_d = '0;
                    staging_d   = '0;
                    overflow_d  = 1'b0;
                    clr_fill    = 1'b1;
                end else begin
                    if (spike_valid) begin
                        if (bit_count_q < FULL_COUNT) begin
                            bit_count_d = bit_count_q + 1'b1;
                            if (bit_idx == LAST_BIT) begin
                                // Word completes this cycle: write it straight
                                // through and start the next one empty.
                                wr_en            = 1'b1;
                                wr_data[bit_idx] = spike_in;
                                staging_d        = '0;
                            end else begin
                                staging_d[bit_idx] = spike_in;
                            end
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                    if (frame_end) begin
                        state_d = FLUSH;
                    end
                end
            end

            FLUSH: begin
                // Partial last word goes out zero-padded; a whole word was
                // already written when its last bit arrived.
                if (bit_idx != '0) begin
                    wr_en = 1'b1;
                end
                if (spike_valid) begin
                    overflow_d = 1'b1;
                end
                state_d = WAIT_SWAP;
            end

            WAIT_SWAP: begin
                if (spike_valid) begin
                    overflow_d = 1'b1;
                end
                if (!frame_ready_q || frame_ack) begin
                    swap          = 1'b1;
                    frame_ready_d = 1'b1;
                    state_d       = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q       <= IDLE;
            bit_count_q   <= '0;
            staging_q     <= '0;
            overflow_q    <= 1'b0;
            frame_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_count_q   <= bit_count_d;
            staging_q     <= staging_d;
            overflow_q    <= overflow_d;
            frame_ready_q <= frame_ready_d;
        end
    end

    axon_pingpong_bank #(
        .WORDS (WORDS),
        .W     (SPIKE_REG_WIDTH),
        .AW    (WORD_ADDR_WIDTH)
    ) u_bank (
        .clk      (clk),
        .rstb     (rstb),
        .clr_fill (clr_fill),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .swap     (swap),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    assign busy        = (state_q != IDLE);
    assign overflow    = overflow_q;
    assign frame_ready = frame_ready_q;
    assign bit_count   = bit_count_q;

endmodule

// File: tb/tb_axon_collector.sv
module tb_axon_collector;

    localparam int W  = 16;
    localparam int AW = 4;
    localparam int CW = 9;

    logic          clk;
    logic          rstb;
    logic          frame_start;
    logic          spike_valid;
    logic          spike_in;
    logic          frame_end;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic          frame_ready;
    logic          frame_ack;
    logic          busy;
    logic          overflow;
    logic [CW-1:0] bit_count;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    axon_collector dut (
        .clk         (clk),
        .rstb        (rstb),
        .frame_start (frame_start),
        .spike_valid (spike_valid),
        .spike_in    (spike_in),
        .frame_end   (frame_end),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_ready (frame_ready),
        .frame_ack   (frame_ack),
        .busy        (busy),
        .overflow    (overflow),
        .bit_count   (bit_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic do_reset();
        rstb = 1'b0;
        tick();
        rstb = 1'b1;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_spike(input logic b);
        spike_valid = 1'b1;
        spike_in    = b;
        tick();
        spike_valid = 1'b0;
        spike_in    = 1'b0;
    endtask

    task automatic end_frame();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    // scoreboard: read words lo..hi and compare against exp_q in order
    task automatic read_and_score(input string tag, input int lo, input int hi);
        logic [W-1:0] exp;
        for (int a = lo; a <= hi; a++) begin
            rd_en   = 1'b1;
            rd_addr = AW'(a);
            tick();
            rd_en = 1'b0;
            if (exp_q.size() == 0) begin
                check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
                exp = exp_q.pop_front();
                check_eq($sformatf("%s_w%0d", tag, a), 32'(rd_data), 32'(exp));
            end
        end
    endtask

    initial begin
        rstb        = 1'b0;
        frame_start = 1'b0;
        spike_valid = 1'b0;
        spike_in    = 1'b0;
        frame_end   = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = '0;
        frame_ack   = 1'b0;
        tick();
        do_reset();

        // reset state
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        check_eq("rst_ready", 32'(frame_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_cnt", 32'(bit_count), 32'd0);

        // full frame, alternating spikes -> 0xAAAA per word
        start_frame();
        check_eq("full_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 256; i++) send_spike(i[0]);
        end_frame();
        tick();
        check_eq("full_ready_early", 32'(frame_ready), 32'd0);
        tick();
        check_eq("full_ready", 32'(frame_ready), 32'd1);
        check_eq("full_busy_idle", 32'(busy), 32'd0);
        check_eq("full_ovf", 32'(overflow), 32'd0);
        check_eq("full_cnt", 32'(bit_count), 32'd256);
        for (int a = 0; a < 16; a++) exp_q.push_back(16'hAAAA);
        read_and_score("full", 0, 15);
        tick();
        check_eq("rd_hold", 32'(rd_data), 32'hAAAA);
        ack();
        check_eq("full_acked", 32'(frame_ready), 32'd0);

        // partial frame: 20 ones
        start_frame();
        for (int i = 0; i < 20; i++) send_spike(1'b1);
        end_frame();
        tick();
        tick();
        check_eq("part_ready", 32'(frame_ready), 32'd1);
        check_eq("part_cnt", 32'(bit_count), 32'd20);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h000F);
        for (int a = 2; a < 16; a++) exp_q.push_back(16'h0000);
        read_and_score("part", 0, 15);
        ack();

        // overflow: 256 spikes of i[1] (0xCCCC) then 2 extra ones
        start_frame();
        for (int i = 0; i < 256; i++) send_spike(i[1]);
        check_eq("ovf_none_yet", 32'(overflow), 32'd0);
        send_spike(1'b1);
        check_eq("ovf_set", 32'(overflow), 32'd1);
        send_spike(1'b1);
        check_eq("ovf_cnt", 32'(bit_count), 32'd256);
        end_frame();
        tick();
        tick();
        check_eq("ovf_ready", 32'(frame_ready), 32'd1);
        for (int a = 0; a < 16; a++) exp_q.push_back(16'hCCCC);
        read_and_score("ovf", 0, 15);
        ack();
        start_frame();
        check_eq("ovf_cleared", 32'(overflow), 32'd0);
        end_frame();
        tick();
        tick();
        ack();

        // ping-pong back-pressure: A = 32 ones, B = 32 zeros, no ack between
        start_frame();
        for (int i = 0; i < 32; i++) send_spike(1'b1);
        end_frame();
        tick();
        tick();
        check_eq("pp_a_ready", 32'(frame_ready), 32'd1);
        start_frame();
        for (int i = 0; i < 32; i++) send_spike(1'b0);
        end_frame();
        tick();
        tick();
        tick();
        check_eq("pp_wait_busy", 32'(busy), 32'd1);
        check_eq("pp_wait_ready", 32'(frame_ready), 32'd1);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'hFFFF);
        read_and_score("pp_a", 0, 1);
        send_spike(1'b1);
        check_eq("pp_wait_ovf", 32'(overflow), 32'd1);
        ack();
        check_eq("pp_swap_ready", 32'(frame_ready), 32'd1);
        check_eq("pp_swap_idle", 32'(busy), 32'd0);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        read_and_score("pp_b", 0, 1);
        ack();
        check_eq("pp_b_acked", 32'(frame_ready), 32'd0);

        // reset mid-frame
        start_frame();
        for (int i = 0; i < 10; i++) send_spike(1'b1);
        do_reset();
        check_eq("mrst_busy", 32'(busy), 32'd0);
        check_eq("mrst_cnt", 32'(bit_count), 32'd0);
        check_eq("mrst_ready", 32'(frame_ready), 32'd0);
        check_eq("mrst_rd", 32'(rd_data), 32'd0);
        exp_q.push_back(16'h0000);
        read_and_score("mrst_stale", 0, 0);

        // fresh frame; 16th spike arrives together with frame_end -> 0xFF00
        start_frame();
        for (int i = 0; i < 15; i++) send_spike(i >= 8);
        spike_valid = 1'b1;
        spike_in    = 1'b1;
        frame_end   = 1'b1;
        tick();
        spike_valid = 1'b0;
        spike_in    = 1'b0;
        frame_end   = 1'b0;
        tick();
        tick();
        check_eq("same_ready", 32'(frame_ready), 32'd1);
        check_eq("same_cnt", 32'(bit_count), 32'd16);
        exp_q.push_back(16'hFF00);
        exp_q.push_back(16'h0000);
        read_and_score("same", 0, 1);
        ack();
        check_eq("same_acked", 32'(frame_ready), 32'd0);

        // frame_ack with frame_ready=0 is ignored
        ack();
        check_eq("idle_ack_ready", 32'(frame_ready), 32'd0);
        check_eq("idle_ack_busy", 32'(busy), 32'd0);
        exp_q.push_back(16'hFF00);
        read_and_score("idle_ack", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
